// File: rtl/mips_rf_pkg.sv
// mips_rf_pkg: shared register-file constants and the write-select sanity check
package mips_rf_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS = 32;
    localparam int DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    function automatic logic onehot_ok(input logic [NUM_REGS-1:0] v);
        return (v & (v - 1'b1)) == '0;
    endfunction
endpackage

// File: rtl/rf_dest_decoder.sv
// rf_dest_decoder: 5-to-32 one-hot decode of the issued destination register
module rf_dest_decoder
    import mips_rf_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] dest,
    output logic [NUM_REGS-1:0]   mask
);
    assign mask = NUM_REGS'(1) << dest;
endmodule

// File: rtl/reg_file_wb.sv
// reg_file_wb: MIPS32 register file with write-back bypass and pending-write scoreboard
module reg_file_wb
    import mips_rf_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [NUM_REGS-1:0]   wr_sel,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0]     rd_data_a,
    output logic [DATA_W-1:0]     rd_data_b,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_dest,
    output logic                  stall,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  sel_err
);
    logic [DATA_W-1:0]   regs [1:NUM_REGS-1];
    logic                wr_ok;
    logic [NUM_REGS-1:0] wr_mask;
    logic [NUM_REGS-1:0] dest_mask;
    logic [NUM_REGS-1:0] set_mask;
    logic                hazard_a;
    logic                hazard_b;

    rf_dest_decoder u_dec (
        .dest(issue_dest),
        .mask(dest_mask)
    );

    // r0 is hard-wired, so bit 0 of every write/set mask is dropped
    assign wr_ok    = wr_en && onehot_ok(wr_sel);
    assign wr_mask  = wr_ok ? {wr_sel[NUM_REGS-1:1], 1'b0} : '0;
    assign set_mask = (issue_valid && !stall) ? {dest_mask[NUM_REGS-1:1], 1'b0} : '0;

    // read ports with same-cycle write-through bypass
    always_comb begin
        rd_data_a = (rd_addr_a == REG_ZERO) ? '0 : wr_mask[rd_addr_a] ? wr_data : regs[rd_addr_a];
        rd_data_b = (rd_addr_b == REG_ZERO) ? '0 : wr_mask[rd_addr_b] ? wr_data : regs[rd_addr_b];
        hazard_a  = busy[rd_addr_a] && (rd_addr_a != REG_ZERO) && !wr_mask[rd_addr_a];
        hazard_b  = busy[rd_addr_b] && (rd_addr_b != REG_ZERO) && !wr_mask[rd_addr_b];
        stall     = issue_valid && (hazard_a || hazard_b);
    end

    // register storage r1..r31
    always_ff @(posedge clk or negedge rst_n) begin
        for (int i = 1; i < NUM_REGS; i++) begin
            if (!rst_n)
                regs[i] <= '0;
            else if (wr_mask[i])
                regs[i] <= wr_data;
        end
    end

    // scoreboard: write-back clears, accepted issue sets (set wins on collision)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= '0;
            sel_err <= 1'b0;
        end else begin
            busy    <= (busy & ~wr_mask) | set_mask;
            sel_err <= wr_en && !onehot_ok(wr_sel);
        end
    end
endmodule
